// File: rtl/cam_op_sequencer.sv
// cam_op_sequencer: command-level controller that owns every control input of
// the cam block. One op (SEARCH, SELECT_FIRST, WRITE, READ) is in flight at a
// time; strobes are timed by a single down-counter reloaded on state entry.
// Optional feature: define CAM_SEQ_MATCH_COUNT_EN to add rsp_count, the
// popcount of tag_wires captured alongside rsp_hit.
//
// state     | meaning
// IDLE      | waiting for a command
// SET       | one lead-in cycle, then set held high for PULSE_CYC
// SET_GAP   | idle GAP_CYC after set
// SRCH      | perform_search held high for PULSE_CYC
// SRCH_GAP  | idle GAP_CYC, then response
// SEL       | one lead-in cycle, then select_first high for PULSE_CYC
// SEL_GAP   | idle GAP_CYC, then response
// WR        | one lead-in cycle, then write_lines driven for PULSE_CYC
// WR_SETTLE | write_lines zero for WRITE_SETTLE_CYC, then response
// RD_WAIT   | idle GAP_CYC, then read_lines captured
// RSP       | response held until rsp_ready
module cam_op_sequencer #(
  parameter int num_bits         = 32,
  parameter int num_cells        = 100,
  parameter int PULSE_CYC        = 4,
  parameter int GAP_CYC          = 4,
  parameter int WRITE_SETTLE_CYC = 16
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [num_bits-1:0]            cmd_data,
  input  logic [num_bits-1:0]            cmd_mask,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [1:0]                     rsp_op,
  output logic                           rsp_hit,
  output logic [num_bits-1:0]            rsp_data,
`ifdef CAM_SEQ_MATCH_COUNT_EN
  output logic [$clog2(num_cells+1)-1:0] rsp_count,
`endif
  output logic [num_bits-1:0]            comparand,
  output logic [num_bits-1:0]            mask,
  output logic                           set,
  output logic                           perform_search,
  output logic                           select_first,
  output logic [2*num_bits-1:0]          write_lines,
  input  logic [num_cells-1:0]           tag_wires,
  input  logic [num_bits-1:0]            read_lines
);

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_SELECT = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC)
                         ? ((PULSE_CYC > WRITE_SETTLE_CYC) ? PULSE_CYC : WRITE_SETTLE_CYC)
                         : ((GAP_CYC > WRITE_SETTLE_CYC) ? GAP_CYC : WRITE_SETTLE_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, SET, SET_GAP, SRCH, SRCH_GAP, SEL, SEL_GAP, WR, WR_SETTLE, RD_WAIT, RSP
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [1:0]            op_q;
  logic [num_bits-1:0]   wr_data;
  logic [num_bits-1:0]   wr_mask;
  logic [2*num_bits-1:0] wr_pattern;
  logic                  capture;

  assign cmd_ready = (state == IDLE) && !rsp_valid;

  // Dual-rail write encoding: even line drives a 1, odd line drives a 0
  always_comb begin
    wr_pattern = '0;
    for (int i = 0; i < num_bits; i++) begin
      wr_pattern[2*i]   = wr_data[i] & wr_mask[i];
      wr_pattern[2*i+1] = ~wr_data[i] & wr_mask[i];
    end
  end

  // The last idle countdown of each op hands over to the response
  always_comb begin
    capture = 1'b0;
    if (cnt == '0) begin
      case (state)
        SRCH_GAP, SEL_GAP, WR_SETTLE, RD_WAIT: capture = 1'b1;
        default:                               capture = 1'b0;
      endcase
    end
  end

`ifdef CAM_SEQ_MATCH_COUNT_EN
  localparam int CNTW = $clog2(num_cells + 1);
  logic [CNTW-1:0] match_count;

  // Number of tagged cells, reported with the response
  always_comb begin
    match_count = '0;
    for (int i = 0; i < num_cells; i++) match_count = match_count + CNTW'(tag_wires[i]);
  end
`endif

  // Sequencer state, strobe timing and response registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      cnt            <= '0;
      op_q           <= '0;
      wr_data        <= '0;
      wr_mask        <= '0;
      comparand      <= '0;
      mask           <= '0;
      set            <= 1'b0;
      perform_search <= 1'b0;
      select_first   <= 1'b0;
      write_lines    <= '0;
      rsp_valid      <= 1'b0;
      rsp_op         <= '0;
      rsp_hit        <= 1'b0;
      rsp_data       <= '0;
`ifdef CAM_SEQ_MATCH_COUNT_EN
      rsp_count      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q <= cmd_op;
            case (cmd_op)
              OP_SEARCH: begin
                comparand <= cmd_data;
                mask      <= cmd_mask;
                state     <= SET;
                cnt       <= CW'(PULSE_CYC);
              end
              OP_SELECT: begin
                state <= SEL;
                cnt   <= CW'(PULSE_CYC);
              end
              OP_WRITE: begin
                wr_data <= cmd_data;
                wr_mask <= cmd_mask;
                state   <= WR;
                cnt     <= CW'(PULSE_CYC);
              end
              default: begin
                state <= RD_WAIT;
                cnt   <= CW'(GAP_CYC);
              end
            endcase
          end
        end
        SET: begin
          if (cnt == '0) begin
            set   <= 1'b0;
            state <= SET_GAP;
            cnt   <= CW'(GAP_CYC - 1);
          end else begin
            set <= 1'b1;
            cnt <= cnt - CW'(1);
          end
        end
        SET_GAP: begin
          if (cnt == '0) begin
            perform_search <= 1'b1;
            state          <= SRCH;
            cnt            <= CW'(PULSE_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SRCH: begin
          if (cnt == '0) begin
            perform_search <= 1'b0;
            state          <= SRCH_GAP;
            cnt            <= CW'(GAP_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SEL: begin
          if (cnt == '0) begin
            select_first <= 1'b0;
            state        <= SEL_GAP;
            cnt          <= CW'(GAP_CYC - 1);
          end else begin
            select_first <= 1'b1;
            cnt          <= cnt - CW'(1);
          end
        end
        WR: begin
          if (cnt == '0) begin
            write_lines <= '0;
            state       <= WR_SETTLE;
            cnt         <= CW'(WRITE_SETTLE_CYC - 1);
          end else begin
            write_lines <= wr_pattern;
            cnt         <= cnt - CW'(1);
          end
        end
        SRCH_GAP, SEL_GAP, WR_SETTLE, RD_WAIT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_op    <= '0;
            rsp_hit   <= 1'b0;
            rsp_data  <= '0;
`ifdef CAM_SEQ_MATCH_COUNT_EN
            rsp_count <= '0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (capture) begin
        state     <= RSP;
        rsp_valid <= 1'b1;
        rsp_op    <= op_q;
        rsp_hit   <= |tag_wires;
        rsp_data  <= (op_q == OP_READ) ? read_lines : '0;
`ifdef CAM_SEQ_MATCH_COUNT_EN
        rsp_count <= match_count;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cam_op_sequencer.sv
// Bench for cam_op_sequencer: drives commands, holds CAM-side inputs steady
// per op, and checks strobes per cycle and responses through a scoreboard.
module tb_cam_op_sequencer;
  localparam int NB   = 32;
  localparam int NC   = 100;
  localparam int P    = 4;
  localparam int G    = 4;
  localparam int WS   = 16;
  localparam int CNTW = $clog2(NC + 1);

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'b00;
  logic [NB-1:0]   cmd_data = '0;
  logic [NB-1:0]   cmd_mask = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_op;
  logic            rsp_hit;
  logic [NB-1:0]   rsp_data;
`ifdef CAM_SEQ_MATCH_COUNT_EN
  logic [CNTW-1:0] rsp_count;
`endif
  logic [NB-1:0]   comparand;
  logic [NB-1:0]   mask;
  logic            set;
  logic            perform_search;
  logic            select_first;
  logic [2*NB-1:0] write_lines;
  logic [NC-1:0]   tag_wires = '0;
  logic [NB-1:0]   read_lines = '0;

  cam_op_sequencer #(
    .num_bits(NB), .num_cells(NC), .PULSE_CYC(P), .GAP_CYC(G), .WRITE_SETTLE_CYC(WS)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_hit(rsp_hit), .rsp_data(rsp_data),
`ifdef CAM_SEQ_MATCH_COUNT_EN
    .rsp_count(rsp_count),
`endif
    .comparand(comparand), .mask(mask), .set(set),
    .perform_search(perform_search), .select_first(select_first),
    .write_lines(write_lines), .tag_wires(tag_wires), .read_lines(read_lines)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (edge %0d)", name, edge_cnt);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]    op;
    logic          hit;
    int            cnt;
    logic [NB-1:0] data;
    int            k;
    int            lat;
  } exp_t;

  exp_t exp_q[$];

  function automatic int latency(input logic [1:0] op);
    case (op)
      2'b00:   return 1 + 2*P + 2*G;
      2'b01:   return 1 + P + G;
      2'b10:   return 1 + P + WS;
      default: return 1 + G;
    endcase
  endfunction

  function automatic logic [2*NB-1:0] expand(input logic [NB-1:0] d, input logic [NB-1:0] m);
    logic [2*NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      r[2*i]   = d[i] & m[i];
      r[2*i+1] = !d[i] & m[i];
    end
    return r;
  endfunction

  function automatic logic [NC-1:0] gen_tags(input int mode);
    logic [127:0] r;
    int a, b, c;
    r = '0;
    case (mode)
      1: r[$urandom_range(0, NC-1)] = 1'b1;
      2: begin
        a = int'($urandom_range(0, NC-1));
        do b = int'($urandom_range(0, NC-1)); while (b == a);
        do c = int'($urandom_range(0, NC-1)); while (c == a || c == b);
        r[a] = 1'b1; r[b] = 1'b1; r[c] = 1'b1;
      end
      3: r = {$urandom, $urandom, $urandom, $urandom};
      default: r = '0;
    endcase
    return r[NC-1:0];
  endfunction

  // current op as seen by the per-cycle strobe checker
  bit            c_valid = 0;
  logic [1:0]    c_op = '0;
  int            c_k = 0;
  logic [NB-1:0] c_data = '0;
  logic [NB-1:0] c_mask = '0;
  logic [NB-1:0] e_cmp = '0;
  logic [NB-1:0] e_msk = '0;

  // Per-cycle strobe and comparand/mask check; value seen here was registered at edge e
  always @(negedge CLK) begin
    logic            es, eps, esel;
    logic [2*NB-1:0] ewl;
    int              e;
    if (RST_N && started) begin
      e = edge_cnt;
      es = 1'b0; eps = 1'b0; esel = 1'b0; ewl = '0;
      if (c_valid) begin
        if (c_op == 2'b00 && e == c_k) begin
          e_cmp = c_data;
          e_msk = c_mask;
        end
        case (c_op)
          2'b00: begin
            es  = (e >= c_k + 1) && (e <= c_k + P);
            eps = (e >= c_k + 1 + P + G) && (e <= c_k + 2*P + G);
          end
          2'b01: esel = (e >= c_k + 1) && (e <= c_k + P);
          2'b10: if ((e >= c_k + 1) && (e <= c_k + P)) ewl = expand(c_data, c_mask);
          default: ;
        endcase
      end
      chk("strobes", 128'({set, perform_search, select_first, write_lines}),
          128'({es, eps, esel, ewl}));
      chk("comparand_mask", 128'({comparand, mask}), 128'({e_cmp, e_msk}));
    end
  end

  // ---------------- response monitor ----------------
  exp_t cur_exp;
  bit   held = 0;
  bit   hs_pending = 0;

  always @(negedge CLK) begin
    if (RST_N && started) begin
      if (hs_pending) begin
        hs_pending = 0;
        held = 0;
        chk("rsp_clear", 128'({rsp_valid, rsp_hit, rsp_op, rsp_data}), 128'(0));
        chk("cmd_ready_after_hs", 128'(cmd_ready), 128'(1));
      end else if (rsp_valid) begin
        if (!held) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (edge %0d)", edge_cnt);
          end else begin
            cur_exp = exp_q.pop_front();
            held = 1;
            chk("rsp_latency", 128'(edge_cnt - cur_exp.k), 128'(cur_exp.lat));
          end
        end
        if (held) begin
          chk("rsp_op", 128'(rsp_op), 128'(cur_exp.op));
          chk("rsp_hit", 128'(rsp_hit), 128'(cur_exp.hit));
          chk("rsp_data", 128'(rsp_data), 128'(cur_exp.data));
`ifdef CAM_SEQ_MATCH_COUNT_EN
          chk("rsp_count", 128'(rsp_count), 128'(cur_exp.cnt));
`endif
          chk("cmd_ready_while_rsp", 128'(cmd_ready), 128'(0));
          if (rsp_ready) hs_pending = 1;
        end
      end
    end
  end

  // ---------------- rsp_ready driver ----------------
  bit   rr_force = 1;
  logic rr_val = 1'b1;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      rsp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- command driver ----------------
  task automatic issue(input logic [1:0] op, input logic [NB-1:0] d, input logic [NB-1:0] m,
                       input int tmode, input logic [NB-1:0] rl);
    exp_t x;
    int   n;
    n = 0;
    @(negedge CLK);
    while (!cmd_ready && n < 300) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_data  = $urandom;
      cmd_mask  = $urandom;
      n++;
      @(negedge CLK);
    end
    if (!cmd_ready) begin
      timeout("cmd_ready_wait");
      cmd_valid = 1'b0;
      return;
    end
    tag_wires  = gen_tags(tmode);
    read_lines = rl;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_data   = d;
    cmd_mask   = m;
    c_op    = op;
    c_k     = edge_cnt + 1;
    c_data  = d;
    c_mask  = m;
    c_valid = 1;
    x.op   = op;
    x.hit  = (tag_wires != '0);
    x.cnt  = $countones(tag_wires);
    x.data = (op == 2'b11) ? rl : '0;
    x.k    = c_k;
    x.lat  = latency(op);
    exp_q.push_back(x);
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = $urandom;
    cmd_mask  = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (!(cmd_ready && exp_q.size() == 0 && !held) && n < 500) begin
      n++;
      @(negedge CLK);
    end
    if (!(cmd_ready && exp_q.size() == 0 && !held)) timeout(name);
  endtask

  initial begin
    int n;
    logic [NB-1:0] word;
    #3;
    chk("reset_cam_outputs", 128'({set, perform_search, select_first, write_lines}), 128'(0));
    chk("reset_rsp", 128'({rsp_valid, rsp_hit, rsp_op, rsp_data, comparand}), 128'(0));
    repeat (3) @(negedge CLK);
    #2;
    RST_N = 1'b1;
    started = 1;
    @(negedge CLK);
    chk("cmd_ready_after_reset", 128'(cmd_ready), 128'(1));

    // WRITE 0xA5 under mask 0xFF
    rr_force = 1; rr_val = 1'b1;
    issue(2'b10, 32'h0000_00A5, 32'h0000_00FF, 3, '0);
    @(negedge CLK);
    chk("write_pattern", 128'(write_lines), 128'(64'h6699));
    wait_idle("write_done");

    // SEARCH matching word, then WRITE must leave comparand alone
    issue(2'b00, 32'h0000_00A5, 32'hFFFF_FFFF, 1, '0);
    issue(2'b10, $urandom, $urandom, 0, '0);
    wait_idle("search_write_done");
    chk("comparand_kept", 128'(comparand), 128'(32'h0000_00A5));

    // SEARCH absent value, then three matching cells
    issue(2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, '0);
    issue(2'b00, 32'h1234_5678, 32'hFFFF_0000, 2, '0);

    // SELECT_FIRST then READ of the selected word
    word = $urandom;
    issue(2'b01, $urandom, $urandom, 1, '0);
    issue(2'b11, $urandom, $urandom, 1, word);
    wait_idle("select_read_done");

    // Backpressure: response held for 10 cycles with junk commands
    rr_val = 1'b0;
    issue(2'b01, $urandom, $urandom, 2, $urandom);
    n = 0;
    @(negedge CLK);
    while (!rsp_valid && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (!rsp_valid) timeout("bp_rsp_valid");
    repeat (10) begin
      chk("bp_cmd_ready", 128'(cmd_ready), 128'(0));
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_data  = $urandom;
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    rr_val = 1'b1;
    wait_idle("bp_release");

    // Reset while set is high
    issue(2'b00, $urandom, $urandom, 3, '0);
    n = 0;
    @(negedge CLK);
    while (!set && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (!set) timeout("set_before_reset");
    #2;
    RST_N = 1'b0;
    exp_q.delete();
    c_valid = 0; held = 0; hs_pending = 0;
    e_cmp = '0; e_msk = '0;
    #1;
    chk("async_reset_cam", 128'({set, perform_search, select_first, write_lines}), 128'(0));
    chk("async_reset_cmp", 128'({comparand, mask}), 128'(0));
    chk("async_reset_rsp", 128'({rsp_valid, rsp_hit, rsp_op, rsp_data}), 128'(0));
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    repeat (3) @(negedge CLK);
    cmd_valid = 1'b0;
    #2;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("cmd_ready_post_reset", 128'(cmd_ready), 128'(1));
    chk("no_rsp_post_reset", 128'(rsp_valid), 128'(0));
    repeat (25) @(negedge CLK);

    // Randomized ops with random response backpressure
    rr_force = 0;
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 3)), $urandom);
    end
    rr_force = 1;
    rr_val = 1'b1;
    wait_idle("final_drain");
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_op_sequencer.md
Name: cam_op_sequencer

Overview:
- Command-level controller for the `cam` block (parameters num_bits, num_cells).
- Accepts one op at a time on a valid/ready command channel: SEARCH, SELECT_FIRST, WRITE or READ.
- Generates the CAM strobes (set, perform_search, select_first, write_lines) with programmable pulse and gap lengths, then returns a response with match status and read data.
- Replaces hand-timed testbench tasks; it is the single owner of all CAM control inputs.

Parameters:
- num_bits, 32, CAM word width.
- num_cells, 100, CAM cell count (width of tag_wires).
- PULSE_CYC, 4, cycles each strobe is held high (>=1).
- GAP_CYC, 4, idle cycles after each strobe before the next step or sampling (>=1).
- WRITE_SETTLE_CYC, 16, idle cycles after a write pulse before the response (>=1).

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  input  2  00 SEARCH, 01 SELECT_FIRST, 10 WRITE, 11 READ.
- cmd_data  input  num_bits  comparand (SEARCH) or value (WRITE).
- cmd_mask  input  num_bits  search mask (SEARCH) or bit-enable mask (WRITE).
- rsp_valid  output  1  response present; held until rsp_ready.
- rsp_ready  input  1  response consumed.
- rsp_op  output  2  op that produced the response.
- rsp_hit  output  1  |tag_wires, sampled at completion.
- rsp_data  output  num_bits  read_lines captured by READ; 0 for other ops.
- comparand  output  num_bits  to CAM.
- mask  output  num_bits  to CAM.
- set  output  1  to CAM.
- perform_search  output  1  to CAM.
- select_first  output  1  to CAM.
- write_lines  output  2*num_bits  to CAM.
- tag_wires  input  num_cells  from CAM.
- read_lines  input  num_bits  from CAM.

Behaviour:
- All outputs are registered except cmd_ready = (state==IDLE) && !rsp_valid.
- Reset (RST_N low, asynchronous, any time, including mid-op): state IDLE; every registered output is 0 (comparand, mask, strobes, write_lines, rsp_*). Any in-flight op is discarded with no response. Commands are ignored while RST_N is low.
- States: IDLE, SET, SET_GAP, SRCH, SRCH_GAP, SEL, SEL_GAP, WR, WR_SETTLE, RD_WAIT, RSP.
- One down-counter, loaded on each state entry, drives every transition.
- Acceptance at edge k. The latencies below are the edge at which rsp_valid rises; the example values use the default parameters.
- SEARCH:
  - Latch comparand <= cmd_data and mask <= cmd_mask at edge k. Both hold until the next accepted SEARCH; WRITE, SELECT_FIRST and READ leave them unchanged.
  - set=1 for PULSE_CYC cycles starting at edge k+1.
  - GAP_CYC cycles idle.
  - perform_search=1 for PULSE_CYC cycles.
  - GAP_CYC cycles idle.
  - rsp_valid at edge k+1+2*PULSE_CYC+2*GAP_CYC (default k+17).
- SELECT_FIRST: select_first=1 for PULSE_CYC cycles, then GAP_CYC idle; rsp at k+1+PULSE_CYC+GAP_CYC (k+9).
- WRITE:
  - For PULSE_CYC cycles, write_lines[2i]=cmd_data[i]&cmd_mask[i] and write_lines[2i+1]=~cmd_data[i]&cmd_mask[i] (latched at accept).
  - Then write_lines=0 for WRITE_SETTLE_CYC cycles.
  - rsp at k+1+PULSE_CYC+WRITE_SETTLE_CYC (k+21).
- READ: no strobe; wait GAP_CYC cycles, then rsp_data <= read_lines; rsp at k+1+GAP_CYC (k+5).
- Response capture:
  - rsp_hit = |tag_wires and rsp_op are captured on the same edge that raises rsp_valid.
  - rsp_data = 0 except for READ.
- Response hold: rsp_valid and all rsp_* stay stable until rsp_valid && rsp_ready.
  - They clear on that edge.
  - cmd_ready rises the following cycle, so there is no back-to-back overlap.
- Strobe exclusivity: at most one of set, perform_search, select_first and (write_lines!=0) is active in any cycle. All are 0 in IDLE and RSP.
- cmd_valid while busy: not accepted; cmd_* may change freely and are ignored.
- Only one op is in flight; there is no queuing.

Optional Feature:
- Macro CAM_SEQ_MATCH_COUNT_EN.
- When defined: adds output rsp_count, width $clog2(num_cells+1).
  - It is the popcount of tag_wires, captured with rsp_hit.
  - It is cleared on reset and on response handshake.
- When undefined: the port and the popcount logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-SEARCH: assert RST_N=0 while set=1 -> all CAM outputs 0 asynchronously, no rsp_valid after release, cmd_ready=1 on the first cycle after release.
- WRITE data=0x0000_00A5, mask=0x0000_00FF, accepted at edge k -> write_lines[15:0]=0x6699 and write_lines[63:16]=0 for 4 cycles from k+1; zeros thereafter; rsp_valid at k+21 with rsp_op=10.
- SEARCH comparand=0x0000_00A5, mask=0xFFFF_FFFF with the CAM model holding the matching word -> set high edges k+1..k+4, perform_search high k+9..k+12, rsp_valid at k+17, rsp_hit=1; comparand still 0xA5 after a subsequent WRITE.
- SEARCH on a value absent from the CAM -> rsp_hit=0; with CAM_SEQ_MATCH_COUNT_EN, rsp_count=0. Three matching cells -> rsp_count=3.
- SELECT_FIRST then READ -> select_first high for exactly 4 cycles, rsp at k+9; READ rsp at k'+5 with rsp_data equal to the selected word, rsp_op=11.
- Backpressure: hold rsp_ready=0 for 10 cycles and toggle cmd_valid/cmd_op meanwhile -> rsp_* stable, cmd_ready=0, no strobes; after rsp_ready=1, cmd_ready=1 the next cycle.
